pc_update: RTL and testbench

PC_UPDATE -- requirements
Module: pc_update

---
 rtl/pc_update_pkg.sv | 42 ++++
 rtl/branch_cond.sv | 28 ++
 rtl/pc_update.sv | 120 ++++++++++++
 tb/tb_pc_update.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pc_update_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pc_update_pkg
// Brief   : Shared CPU encodings for PC update: FSM states, branch ops,
//           exception causes and default handler vector addresses.
// Revision: 1.0
// ============================================================================
package pc_update_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FETCH   = 2'd2,
    ST_LOAD    = 2'd3
  } exc_state_t;

  typedef enum logic [1:0] {
    BR_BEQ = 2'b00,
    BR_BNE = 2'b01,
    BR_BGT = 2'b10,
    BR_BLE = 2'b11
  } branch_op_t;

  typedef enum logic [1:0] {
    CAUSE_OPCODE = 2'd0,
    CAUSE_OVF    = 2'd1,
    CAUSE_DIV0   = 2'd2
  } exc_cause_t;

  localparam logic [31:0] VEC_OPCODE_DFLT = 32'd253;
  localparam logic [31:0] VEC_OVF_DFLT    = 32'd254;
  localparam logic [31:0] VEC_DIV0_DFLT   = 32'd255;

  // Lowest request bit wins: opcode > overflow > div0.
  function automatic exc_cause_t prio_cause(input logic [2:0] req);
    if (req[0])      return CAUSE_OPCODE;
    else if (req[1]) return CAUSE_OVF;
    else             return CAUSE_DIV0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/branch_cond.sv
`default_nettype none
// ============================================================================
// Module  : branch_cond
// Brief   : Combinational branch-taken evaluation from ALU flags.
// Revision: 1.0
// ============================================================================
module branch_cond
  import pc_update_pkg::*;
(
  input  branch_op_t branch_op,
  input  logic       alu_zero,
  input  logic       alu_gt,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    case (branch_op)
      BR_BEQ:  taken =  alu_zero;
      BR_BNE:  taken = !alu_zero;
      BR_BGT:  taken =  alu_gt;
      BR_BLE:  taken = !alu_gt;
      default: taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/pc_update.sv
`default_nettype none
// ============================================================================
// Module  : pc_update
// Brief   : Program counter with branch qualification and a 4-state
//           exception sequence (capture EPC, fetch vector byte, load PC).
// Revision: 1.0
// ============================================================================
module pc_update
  import pc_update_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] VEC_OPCODE = VEC_OPCODE_DFLT,
  parameter logic [31:0] VEC_OVF    = VEC_OVF_DFLT,
  parameter logic [31:0] VEC_DIV0   = VEC_DIV0_DFLT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_next,
  input  logic        pc_write,
  input  logic        pc_write_cond,
  input  logic [1:0]  branch_op,
  input  logic        alu_zero,
  input  logic        alu_gt,
  input  logic [2:0]  exc_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [31:0] pc,
  output logic [31:0] epc,
  output logic        exc_busy,
  output logic        exc_mem_rd,
  output logic [31:0] exc_mem_addr,
  output logic [1:0]  exc_cause,
  output logic        exc_done
);

  exc_state_t  state_q, state_d;
  exc_cause_t  cause_q, cause_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] epc_q, epc_d;
  logic [7:0]  handler_q, handler_d;
  logic        branch_taken;

  branch_cond u_branch_cond (
    .branch_op (branch_op_t'(branch_op)),
    .alu_zero  (alu_zero),
    .alu_gt    (alu_gt),
    .taken     (branch_taken)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cause_q   <= CAUSE_OPCODE;
      pc_q      <= RESET_PC;
      epc_q     <= 32'd0;
      handler_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      cause_q   <= cause_d;
      pc_q      <= pc_d;
      epc_q     <= epc_d;
      handler_q <= handler_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    pc_d      = pc_q;
    epc_d     = epc_q;
    handler_d = handler_q;
    case (state_q)
      ST_IDLE: begin
        // An exception request pre-empts any PC write on the same edge.
        if (|exc_req) begin
          cause_d = prio_cause(exc_req);
          state_d = ST_CAPTURE;
        end else if (pc_write || (pc_write_cond && branch_taken)) begin
          pc_d = pc_next;
        end
      end
      ST_CAPTURE: begin
        epc_d   = pc_q - 32'd4;
        state_d = ST_FETCH;
      end
      ST_FETCH: begin
        if (mem_ack) begin
          handler_d = mem_rdata;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        pc_d    = {24'b0, handler_q};
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    exc_mem_addr = 32'd0;
    if (state_q == ST_FETCH) begin
      case (cause_q)
        CAUSE_OPCODE: exc_mem_addr = VEC_OPCODE;
        CAUSE_OVF:    exc_mem_addr = VEC_OVF;
        CAUSE_DIV0:   exc_mem_addr = VEC_DIV0;
        default:      exc_mem_addr = 32'd0;
      endcase
    end
  end

  assign pc         = pc_q;
  assign epc        = epc_q;
  assign exc_cause  = cause_q;
  assign exc_busy   = (state_q != ST_IDLE);
  assign exc_mem_rd = (state_q == ST_FETCH);
  assign exc_done   = (state_q == ST_LOAD);

endmodule
`default_nettype wire

// File: tb/tb_pc_update.sv
`default_nettype none
// ============================================================================
// Module  : tb_pc_update
// Brief   : Directed self-checking bench for pc_update.
// Revision: 1.0
// ============================================================================
module tb_pc_update;

  logic        clk;
  logic        reset;
  logic [31:0] pc_next;
  logic        pc_write;
  logic        pc_write_cond;
  logic [1:0]  branch_op;
  logic        alu_zero;
  logic        alu_gt;
  logic [2:0]  exc_req;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic [31:0] pc;
  logic [31:0] epc;
  logic        exc_busy;
  logic        exc_mem_rd;
  logic [31:0] exc_mem_addr;
  logic [1:0]  exc_cause;
  logic        exc_done;

  int n_cmp;
  int n_err;

  pc_update u_dut (
    .clk           (clk),
    .reset         (reset),
    .pc_next       (pc_next),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .branch_op     (branch_op),
    .alu_zero      (alu_zero),
    .alu_gt        (alu_gt),
    .exc_req       (exc_req),
    .mem_ack       (mem_ack),
    .mem_rdata     (mem_rdata),
    .pc            (pc),
    .epc           (epc),
    .exc_busy      (exc_busy),
    .exc_mem_rd    (exc_mem_rd),
    .exc_mem_addr  (exc_mem_addr),
    .exc_cause     (exc_cause),
    .exc_done      (exc_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    exc_req       = 3'b000;
    mem_ack       = 1'b0;
  endtask

  task automatic load_pc(input logic [31:0] val);
    pc_next  = val;
    pc_write = 1'b1;
    step();
    pc_write = 1'b0;
  endtask

  typedef struct {
    logic [1:0] op;
    logic       zero;
    logic       gt;
    logic       taken;
  } br_vec_t;

  br_vec_t br_tab [8];

  initial begin
    n_cmp = 0;
    n_err = 0;
    reset = 1'b0;
    pc_next = 32'd0;
    branch_op = 2'b00;
    alu_zero = 1'b0;
    alu_gt = 1'b0;
    mem_rdata = 8'd0;
    idle_inputs();

    br_tab[0] = '{2'b00, 1'b0, 1'b1, 1'b0};
    br_tab[1] = '{2'b00, 1'b1, 1'b0, 1'b1};
    br_tab[2] = '{2'b01, 1'b0, 1'b0, 1'b1};
    br_tab[3] = '{2'b01, 1'b1, 1'b1, 1'b0};
    br_tab[4] = '{2'b10, 1'b1, 1'b0, 1'b0};
    br_tab[5] = '{2'b10, 1'b0, 1'b1, 1'b1};
    br_tab[6] = '{2'b11, 1'b1, 1'b0, 1'b1};
    br_tab[7] = '{2'b11, 1'b0, 1'b1, 1'b0};

    step();
    step();
    check_val("rst_pc", pc, 32'h0);
    check_val("rst_epc", epc, 32'h0);
    check_val("rst_busy", {31'd0, exc_busy}, 32'd0);
    check_val("rst_mem_rd", {31'd0, exc_mem_rd}, 32'd0);
    check_val("rst_done", {31'd0, exc_done}, 32'd0);
    check_val("rst_cause", {30'd0, exc_cause}, 32'd0);
    reset = 1'b1;

    load_pc(32'h40);
    check_val("wr_pc", pc, 32'h40);
    check_val("wr_epc", epc, 32'h0);

    // Condition true but no write request: PC holds.
    branch_op = 2'b00; alu_zero = 1'b1;
    pc_next = 32'h77;
    step();
    check_val("no_req_hold", pc, 32'h40);

    for (int i = 0; i < 8; i++) begin
      load_pc(32'h40);
      branch_op     = br_tab[i].op;
      alu_zero      = br_tab[i].zero;
      alu_gt        = br_tab[i].gt;
      pc_next       = 32'h100 + 32'(i) * 32'd4;
      pc_write_cond = 1'b1;
      step();
      pc_write_cond = 1'b0;
      check_val($sformatf("branch_%0d", i), pc,
                br_tab[i].taken ? 32'h100 + 32'(i) * 32'd4 : 32'h40);
    end

    // Overflow+div0 together with a pc_write: overflow wins, PC untouched.
    load_pc(32'h104);
    exc_req  = 3'b110;
    pc_write = 1'b1;
    pc_next  = 32'h999;
    step();
    idle_inputs();
    check_val("ovf_pc_hold", pc, 32'h104);
    check_val("ovf_cause", {30'd0, exc_cause}, 32'd1);
    check_val("ovf_busy", {31'd0, exc_busy}, 32'd1);
    check_val("cap_addr_zero", exc_mem_addr, 32'd0);
    step();
    check_val("ovf_epc", epc, 32'h100);
    check_val("ovf_mem_rd", {31'd0, exc_mem_rd}, 32'd1);
    check_val("ovf_addr", exc_mem_addr, 32'd254);
    mem_ack   = 1'b1;
    mem_rdata = 8'h3C;
    step();
    mem_ack = 1'b0;
    check_val("ovf_done_hi", {31'd0, exc_done}, 32'd1);
    check_val("ovf_mem_rd_off", {31'd0, exc_mem_rd}, 32'd0);
    step();
    check_val("ovf_pc", pc, 32'h3C);
    check_val("ovf_done_lo", {31'd0, exc_done}, 32'd0);
    check_val("ovf_idle", {31'd0, exc_busy}, 32'd0);

    // Opcode + div0 from PC 0: opcode wins, EPC wraps, ack delayed.
    load_pc(32'h0);
    exc_req = 3'b101;
    step();
    exc_req = 3'b000;
    check_val("op_cause", {30'd0, exc_cause}, 32'd0);
    step();
    check_val("op_epc", epc, 32'hFFFF_FFFC);
    for (int i = 0; i < 5; i++) begin
      check_val($sformatf("op_rd_%0d", i), {31'd0, exc_mem_rd}, 32'd1);
      check_val($sformatf("op_addr_%0d", i), exc_mem_addr, 32'd253);
      if (i == 2) begin
        exc_req       = 3'b100;
        pc_write      = 1'b1;
        pc_write_cond = 1'b1;
        pc_next       = 32'h55;
      end
      step();
      idle_inputs();
    end
    check_val("busy_ign_pc", pc, 32'h0);
    check_val("busy_ign_cause", {30'd0, exc_cause}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 8'h80;
    step();
    mem_ack = 1'b0;
    step();
    check_val("op_pc", pc, 32'h80);
    step();
    check_val("no_queue_busy", {31'd0, exc_busy}, 32'd0);
    check_val("no_queue_pc", pc, 32'h80);

    // Reset during FETCH aborts the sequence immediately.
    exc_req = 3'b100;
    step();
    exc_req = 3'b000;
    step();
    check_val("div0_addr", exc_mem_addr, 32'd255);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_pc", pc, 32'h0);
    check_val("arst_epc", epc, 32'h0);
    check_val("arst_cause", {30'd0, exc_cause}, 32'd0);
    check_val("arst_busy", {31'd0, exc_busy}, 32'd0);
    check_val("arst_mem_rd", {31'd0, exc_mem_rd}, 32'd0);
    check_val("arst_addr", exc_mem_addr, 32'd0);
    @(negedge clk);
    reset     = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 8'h77;
    step();
    step();
    mem_ack = 1'b0;
    check_val("post_rst_pc", pc, 32'h0);
    check_val("post_rst_epc", epc, 32'h0);
    check_val("post_rst_busy", {31'd0, exc_busy}, 32'd0);

    load_pc(32'h300);
    check_val("first_wr_after_rst", pc, 32'h300);

    // Stray acknowledge in IDLE.
    mem_ack   = 1'b1;
    mem_rdata = 8'h11;
    step();
    mem_ack = 1'b0;
    check_val("stray_ack_pc", pc, 32'h300);
    check_val("stray_ack_busy", {31'd0, exc_busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
